// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer
// Fetch controller between the read-only instruction memory and decode.
// It owns the fetch PC and holds Address stable for RD_WAIT+1 cycles, which
// is the memory read window. On the edge that ends the window it captures
// Data, together with the PC it belongs to, into a small instruction queue.
// Decode drains the queue through a valid/ready handshake. A branch redirect
// flushes the queue and restarts fetching at the new target.
//
// Ports:
//   CLK         in   1   system clock, rising edge
//   resetl      in   1   asynchronous active-low reset
//   Address     out  64  fetch address driven to instruction memory
//   Data        in   32  instruction memory read data
//   Redirect    in   1   branch/jump taken; restart at RedirectPC
//   RedirectPC  in   64  new fetch target (bits [1:0] ignored)
//   Instr       out  32  instruction at queue head
//   InstrPC     out  64  PC of Instr
//   InstrValid  out  1   queue non-empty
//   InstrReady  in   1   decode accepts the head this cycle
//   FetchHold   out  1   read complete but queue full (HOLD state)

module imem_fetch_sequencer #(
  parameter int unsigned RD_WAIT  = 2,
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        CLK,
  input  logic        resetl,
  output logic [63:0] Address,
  input  logic [31:0] Data,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC,
  output logic [31:0] Instr,
  output logic [63:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic        FetchHold
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = $clog2(QDEPTH + 1);
  localparam logic [3:0]      WaitInit = 4'(RD_WAIT);
  localparam logic [CntW-1:0] Depth    = CntW'(QDEPTH);

  typedef enum logic {StWait, StHold} state_t;

  state_t          state, stateNext;
  logic [3:0]      waitCount, waitCountNext;
  logic [63:0]     addressNext;

  logic [31:0]     instrMem [QDEPTH];
  logic [63:0]     pcMem    [QDEPTH];
  logic [PtrW-1:0] rdPtr, wrPtr;
  logic [CntW-1:0] count;

  logic            queueFull;
  logic            dequeue;
  logic            readDone;
  logic            push;

  // A read is complete once the window counter has run out; in HOLD the
  // read stays complete until there is room to store it. A dequeue on the
  // same edge frees a slot, so a full queue can still accept the push.
  // Redirect cancels both the push and the dequeue.
  always_comb begin
    queueFull = (count == Depth);
    dequeue   = (count != '0) && InstrReady && !Redirect;
    readDone  = (state == StHold) || (waitCount == 4'd0);
    push      = !Redirect && readDone && (!queueFull || dequeue);
  end

  // Fetch state, window counter and fetch address registers.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state     <= StWait;
      waitCount <= WaitInit;
      Address   <= RESET_PC;
    end else begin
      state     <= stateNext;
      waitCount <= waitCountNext;
      Address   <= addressNext;
    end
  end

  // Next-state logic. A redirect overrides everything else and aborts any
  // read in flight, so a stale instruction never reaches the queue. The
  // address wraps naturally through the 64-bit add.
  always_comb begin
    stateNext     = state;
    waitCountNext = waitCount;
    addressNext   = Address;
    if (Redirect) begin
      stateNext     = StWait;
      waitCountNext = WaitInit;
      addressNext   = RedirectPC & ~64'h3;
    end else begin
      case (state)
        StWait: begin
          if (waitCount != 4'd0) begin
            waitCountNext = waitCount - 4'd1;
          end else if (push) begin
            waitCountNext = WaitInit;
            addressNext   = Address + 64'd4;
          end else begin
            stateNext = StHold;
          end
        end
        StHold: begin
          if (push) begin
            stateNext     = StWait;
            waitCountNext = WaitInit;
            addressNext   = Address + 64'd4;
          end
        end
        default: stateNext = StWait;
      endcase
    end
  end

  // Queue bookkeeping. The pointers wrap naturally because QDEPTH is a
  // power of two. The count tells full from empty, so all QDEPTH entries
  // are usable.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (Redirect) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PtrW'(1);
      end
      if (dequeue) begin
        rdPtr <= rdPtr + PtrW'(1);
      end
      case ({push, dequeue})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset: the outputs are gated by the count, so
  // unused entries are never visible. Data is stored verbatim.
  always_ff @(posedge CLK) begin
    if (push) begin
      instrMem[wrPtr] <= Data;
      pcMem[wrPtr]    <= Address;
    end
  end

  // The head is presented straight from storage. It reads as zero whenever
  // the queue is empty, which also gives the required values in reset.
  always_comb begin
    InstrValid = (count != '0);
    Instr      = InstrValid ? instrMem[rdPtr] : 32'h0;
    InstrPC    = InstrValid ? pcMem[rdPtr] : 64'h0;
    FetchHold  = (state == StHold);
  end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// tb_imem_fetch_sequencer
// Testbench for imem_fetch_sequencer. The main instance (RD_WAIT=2,
// QDEPTH=2) sees directed and random stimulus and is checked against a
// reference model through a scoreboard. A second instance (RD_WAIT=0) is
// checked for back-to-back delivery of one instruction per cycle.

module tb_imem_fetch_sequencer;

  localparam int unsigned RdWait = 2;
  localparam int unsigned QDepth = 2;
  localparam logic [63:0] ResetPc = 64'h0;

  logic        CLK;
  logic        resetl;
  logic [63:0] Address;
  logic [31:0] Data;
  logic        Redirect;
  logic [63:0] RedirectPC;
  logic [31:0] Instr;
  logic [63:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        FetchHold;

  logic        resetl0;
  logic [63:0] address0;
  logic [31:0] data0;
  logic [31:0] instr0;
  logic [63:0] instrPc0;
  logic        instrValid0;
  logic        fetchHold0;

  int checks = 0;
  int errors = 0;
  bit dut0Done = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  entry_t      expQ[$];
  logic [63:0] mPc;
  int unsigned waitLeft;
  bit          holding;

  // The instruction memory contents. The first two words are real
  // instructions; every other word is a hash of its address.
  function automatic logic [31:0] memFn(input logic [63:0] a);
    case (a)
      64'h0:   return 32'hF840_03E9;
      64'h4:   return 32'hF840_83EA;
      default: return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
    endcase
  endfunction

  assign Data  = memFn(Address);
  assign data0 = memFn(address0);

  imem_fetch_sequencer #(
    .RD_WAIT (RdWait),
    .RESET_PC(ResetPc),
    .QDEPTH  (QDepth)
  ) dut (
    .CLK       (CLK),
    .resetl    (resetl),
    .Address   (Address),
    .Data      (Data),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC),
    .Instr     (Instr),
    .InstrPC   (InstrPC),
    .InstrValid(InstrValid),
    .InstrReady(InstrReady),
    .FetchHold (FetchHold)
  );

  imem_fetch_sequencer #(
    .RD_WAIT (0),
    .RESET_PC(64'h0),
    .QDEPTH  (2)
  ) dut0 (
    .CLK       (CLK),
    .resetl    (resetl0),
    .Address   (address0),
    .Data      (data0),
    .Redirect  (1'b0),
    .RedirectPC(64'h0),
    .Instr     (instr0),
    .InstrPC   (instrPc0),
    .InstrValid(instrValid0),
    .InstrReady(1'b1),
    .FetchHold (fetchHold0)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [95:0] actual,
                             input logic [95:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 2 time units after a rising edge and take effect at the
  // next rising edge.
  task automatic applyStimulus(input bit redir, input logic [63:0] rpc, input bit ready);
    @(posedge CLK);
    #2;
    Redirect   = redir;
    RedirectPC = rpc;
    InstrReady = ready;
  endtask

  // Reference model. Each fetch waits RdWait edges and then completes.
  // A completed fetch is stored if the queue has room; otherwise the model
  // holds. The monitor has already popped any entry dequeued on this edge,
  // so expQ.size() is the occupancy after that dequeue.
  always @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      expQ.delete();
      mPc      = ResetPc;
      waitLeft = RdWait;
      holding  = 1'b0;
    end else if (Redirect) begin
      expQ.delete();
      mPc      = {RedirectPC[63:2], 2'b00};
      waitLeft = RdWait;
      holding  = 1'b0;
    end else if (waitLeft > 0) begin
      waitLeft--;
    end else if (expQ.size() < QDepth) begin
      expQ.push_back({memFn(mPc), mPc});
      mPc      = mPc + 64'd4;
      waitLeft = RdWait;
      holding  = 1'b0;
    end else begin
      holding = 1'b1;
    end
  end

  // Monitor: compares the visible outputs with the model between edges.
  // It pops the expected head whenever the upcoming edge will dequeue it.
  always @(negedge CLK) begin
    checkOutput("instrValid", 96'(InstrValid), 96'(expQ.size() != 0));
    if (expQ.size() != 0) begin
      checkOutput("instr", 96'(Instr), 96'(expQ[0].instr));
      checkOutput("instrPc", 96'(InstrPC), 96'(expQ[0].pc));
      if (InstrReady) begin
        void'(expQ.pop_front());
      end
    end
    checkOutput("address", 96'(Address), 96'(mPc));
    checkOutput("fetchHold", 96'(FetchHold), 96'(holding));
  end

  // RD_WAIT=0 instance: after the first edge out of reset, each cycle
  // shows the next sequential instruction with no bubbles.
  initial begin
    resetl0 = 1'b0;
    repeat (2) @(posedge CLK);
    #2 resetl0 = 1'b1;
    checkOutput("dut0ValidReset", 96'(instrValid0), 96'(0));
    @(posedge CLK);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checkOutput("dut0Valid", 96'(instrValid0), 96'(1));
      checkOutput("dut0InstrPc", 96'(instrPc0), 96'(64'(4 * i)));
      checkOutput("dut0Instr", 96'(instr0), 96'(memFn(64'(4 * i))));
      checkOutput("dut0Address", 96'(address0), 96'(64'(4 * (i + 1))));
      checkOutput("dut0Hold", 96'(fetchHold0), 96'(0));
    end
    dut0Done = 1'b1;
  end

  // Asserts reset away from any clock edge and checks that the outputs
  // reach their reset values without waiting for an edge.
  task automatic asyncResetPulse(input string tag);
    @(posedge CLK);
    #3 resetl = 1'b0;
    #1;
    checkOutput({tag, "Address"}, 96'(Address), 96'(ResetPc));
    checkOutput({tag, "Valid"}, 96'(InstrValid), 96'(0));
    checkOutput({tag, "Hold"}, 96'(FetchHold), 96'(0));
    checkOutput({tag, "Instr"}, 96'(Instr), 96'(0));
    checkOutput({tag, "InstrPc"}, 96'(InstrPC), 96'(0));
    @(posedge CLK);
    #2 resetl = 1'b1;
  endtask

  initial begin
    resetl     = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 64'h0;
    InstrReady = 1'b1;
    #1;
    checkOutput("resetAddress", 96'(Address), 96'(ResetPc));
    checkOutput("resetValid", 96'(InstrValid), 96'(0));
    checkOutput("resetInstr", 96'(Instr), 96'(0));
    checkOutput("resetInstrPc", 96'(InstrPC), 96'(0));
    checkOutput("resetHold", 96'(FetchHold), 96'(0));
    repeat (2) @(posedge CLK);
    #2 resetl = 1'b1;

    // Free-running fetch with decode always ready.
    repeat (10) applyStimulus(1'b0, 64'h0, 1'b1);

    // Decode stalls until the queue fills and fetch holds, then accepts
    // a single instruction.
    repeat (12) applyStimulus(1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1);
    repeat (4) applyStimulus(1'b0, 64'h0, 1'b0);
    repeat (6) applyStimulus(1'b0, 64'h0, 1'b1);

    // Redirect while one entry is queued and the window counter is 1.
    applyStimulus(1'b1, 64'h40, 1'b0);
    repeat (4) applyStimulus(1'b0, 64'h0, 1'b0);
    applyStimulus(1'b1, 64'h1C, 1'b0);
    repeat (8) applyStimulus(1'b0, 64'h0, 1'b1);

    // Redirect in HOLD with a full queue and a same-cycle dequeue. The
    // target's low bits must be ignored.
    repeat (12) applyStimulus(1'b0, 64'h0, 1'b0);
    applyStimulus(1'b1, 64'h0000_0000_0000_2003, 1'b1);
    repeat (8) applyStimulus(1'b0, 64'h0, 1'b1);

    // Address wrap at the top of the address space.
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    repeat (8) applyStimulus(1'b0, 64'h0, 1'b1);

    // Random traffic with occasional redirects to arbitrary targets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0),
                    {$urandom, $urandom},
                    ($urandom_range(0, 3) != 0));
    end

    // Reset mid-window with one entry queued.
    applyStimulus(1'b1, 64'h1000, 1'b0);
    repeat (4) applyStimulus(1'b0, 64'h0, 1'b0);
    asyncResetPulse("rstMidWindow");
    repeat (6) applyStimulus(1'b0, 64'h0, 1'b1);

    // Reset in HOLD.
    repeat (12) applyStimulus(1'b0, 64'h0, 1'b0);
    asyncResetPulse("rstMidHold");
    repeat (10) applyStimulus(1'b0, 64'h0, 1'b1);

    for (int i = 0; i < 100 && !dut0Done; i++) begin
      @(posedge CLK);
    end
    if (!dut0Done) begin
      checkOutput("dut0Timeout", 96'(0), 96'(1));
    end

    @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
- Fetch controller that sequences the read-only instruction memory (64-bit Address in, 32-bit Data out, multi-cycle read delay) on behalf of the decode stage.
- Owns the fetch PC and holds Address stable for a programmable read window, then captures Data into a small instruction queue.
- Presents queued instructions with a valid/ready handshake and supports branch redirect with flush.
- Sits between the instruction memory and the decode/control logic of the processor.

Parameters:
- RD_WAIT, 2, extra cycles Address is held before Data is sampled (legal 0..15); read window = RD_WAIT+1 cycles.
- RESET_PC, 64'h0, fetch PC loaded on reset.
- QDEPTH, 2, instruction queue entries (power of two, 2..8).

Ports:
- CLK  input  1  system clock, rising edge.
- resetl  input  1  asynchronous, active-low reset.
- Address  output  64  address driven to instruction memory.
- Data  input  32  instruction memory read data.
- Redirect  input  1  branch/jump taken; load RedirectPC.
- RedirectPC  input  64  new fetch target, word aligned.
- Instr  output  32  instruction at queue head.
- InstrPC  output  64  PC of Instr.
- InstrValid  output  1  queue non-empty.
- InstrReady  input  1  decode accepts head this cycle.
- FetchHold  output  1  high while in HOLD state (queue full, read complete).

Behaviour:
- Reset is asynchronous and active-low on resetl, single clock CLK. While resetl=0: Address=RESET_PC, queue empty, InstrValid=0, Instr=32'h0, InstrPC=64'h0, FetchHold=0, state=WAIT, wait counter=RD_WAIT. Release takes effect at the next rising edge.
- States:
  - WAIT: counter decrements each edge while nonzero.
  - At an edge with counter==0:
    - If queue not full, or full with a dequeue this cycle: push {Data, Address}, Address+=4, counter=RD_WAIT, stay in WAIT.
    - Otherwise go to HOLD with Address unchanged.
  - HOLD: Address held. At the first edge where space exists (including same-cycle dequeue), push {Data, Address}, Address+=4, counter=RD_WAIT, return to WAIT.
- Timing: Address is stable for exactly RD_WAIT+1 cycles per fetch when not blocked. The push occurs on the edge ending that window. InstrValid rises the cycle after the push. Throughput is 1 instruction per RD_WAIT+1 cycles.
- Handshake: dequeue on an edge with InstrValid=1 and InstrReady=1. Instr and InstrPC reflect the head combinationally from queue storage. The head is stable while InstrValid=1 and InstrReady=0. Dequeue from empty is ignored.
- Redirect (sampled at an edge) has priority over all other events in that cycle:
  - Queue flushed; any same-cycle push and dequeue discarded.
  - Address=RedirectPC, counter=RD_WAIT, state=WAIT.
  - InstrValid=0 the following cycle.
- Redirect during HOLD or mid-window aborts the pending read; no stale instruction is ever pushed.
- RedirectPC[1:0] is ignored (forced to 00).
- Address wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC + 4 -> 0).
- Data is captured verbatim, including X; no decoding is done here.
- Queue full and empty are tracked with pointers plus count; QDEPTH entries are usable.
- Reset asserted mid-window or mid-HOLD returns all outputs to reset values immediately (asynchronously).

Test Plan:
- Reset release, RD_WAIT=2, InstrReady=1, memory holds F84003E9 @0, F84083EA @4 -> Address 0 held 3 cycles; InstrValid rises in cycle 4 with Instr=F84003E9, InstrPC=0; Address=4 from cycle 4; next push 3 cycles later.
- InstrReady=0 from reset -> queue fills with PCs 0 and 4; Address=8 enters HOLD, FetchHold=1; InstrReady pulsed 1 cycle -> same-edge pop of PC 0 and push of PC 8; FetchHold=0; next Address=C.
- Redirect=1, RedirectPC=64'h1C, issued while WAIT counter=1 with one queued entry -> next cycle InstrValid=0, Address=1C; first instruction after redirect has InstrPC=1C and arrives RD_WAIT+1 cycles later.
- Redirect in HOLD with queue full and InstrReady=1 in the same cycle -> no pop visible, queue empty, Address=RedirectPC, FetchHold=0.
- RD_WAIT=0 with continuous InstrReady=1 -> one instruction per cycle; InstrPC sequence 0,4,8,C with no bubbles.
- Redirect to 64'hFFFF_FFFF_FFFF_FFFC -> following Address=0; resetl pulsed low mid-window -> Address=RESET_PC and InstrValid=0 without waiting for a clock edge.
